// File: rtl/lru_list_sa_pkg.sv
// Shared types and width helpers for the set-associative LRU tracker.
package lru_pkg;

    // Operation applied to one way of one set.
    typedef enum logic {
        LRU_TOUCH  = 1'b0,  // promote way to MRU (head)
        LRU_DEMOTE = 1'b1   // push way to LRU (tail)
    } lru_op_e;

    // Set index width; stays at least one bit wide even for a single set.
    function automatic int set_w(input int num_sets);
        return (num_sets <= 1) ? 1 : $clog2(num_sets);
    endfunction

endpackage

// File: rtl/lru_list_sa_if.sv
// Operation and victim-query bus between the hit/fill logic and the LRU tracker.
interface lru_list_sa_if
    import lru_pkg::*;
#(
    parameter int NUM_WAYS = 8,
    parameter int NUM_SETS = 16
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = set_w(NUM_SETS);

    logic             op_valid;
    lru_op_e          op_type;
    logic [SET_W-1:0] op_set;
    logic [WAY_W-1:0] op_way;
    logic             op_err;
    logic             qry_valid;
    logic [SET_W-1:0] qry_set;
    logic             vic_valid;
    logic [WAY_W-1:0] vic_way;

    modport master (
        output op_valid, op_type, op_set, op_way, qry_valid, qry_set,
        input  op_err, vic_valid, vic_way
    );

    modport slave (
        input  op_valid, op_type, op_set, op_way, qry_valid, qry_set,
        output op_err, vic_valid, vic_way
    );

endinterface

// File: rtl/lru_list_sa_set.sv
// One set's doubly linked recency list: head = MRU way, tail = LRU way.
module lru_list_set
    import lru_pkg::*;
#(
    parameter int NUM_WAYS = 8,
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  lru_op_e          op_type,
    input  logic [WAY_W-1:0] way,
    output logic [WAY_W-1:0] tail
);

    logic [WAY_W-1:0] next_q [NUM_WAYS];
    logic [WAY_W-1:0] next_d [NUM_WAYS];
    logic [WAY_W-1:0] prev_q [NUM_WAYS];
    logic [WAY_W-1:0] prev_d [NUM_WAYS];
    logic [WAY_W-1:0] head_q, head_d;
    logic [WAY_W-1:0] tail_q, tail_d;

    // Neighbours of the addressed way, used to unlink it from the middle.
    logic [WAY_W-1:0] way_prev;
    logic [WAY_W-1:0] way_next;

    assign way_prev = prev_q[way];
    assign way_next = next_q[way];
    assign tail     = tail_q;

    // Relink the list for a TOUCH (move to head) or DEMOTE (move to tail).
    always_comb begin
        // NOTE: every next-state variable is defaulted to its current value
        // first, so paths that do not touch it cannot infer a latch.
        next_d = next_q;
        prev_d = prev_q;
        head_d = head_q;
        tail_d = tail_q;
        if (en) begin
            if (op_type == LRU_TOUCH) begin
                if (way != head_q) begin
                    if (way == tail_q) begin
                        tail_d = way_prev;
                    end else begin
                        next_d[way_prev] = way_next;
                        prev_d[way_next] = way_prev;
                    end
                    next_d[way]    = head_q;
                    prev_d[head_q] = way;
                    head_d         = way;
                end
            end else begin
                if (way != tail_q) begin
                    if (way == head_q) begin
                        head_d = way_next;
                    end else begin
                        next_d[way_prev] = way_next;
                        prev_d[way_next] = way_prev;
                    end
                    prev_d[way]    = tail_q;
                    next_d[tail_q] = way;
                    tail_d         = way;
                end
            end
        end
    end

    // List state register; reset restores the identity order 0..NUM_WAYS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these link arrays are small flop arrays whose reset value
            // is the defined initial order, so they are reset like any
            // control state rather than left uninitialised as a RAM would be.
            for (int i = 0; i < NUM_WAYS; i++) begin
                next_q[i] <= WAY_W'((i + 1) % NUM_WAYS);
                prev_q[i] <= WAY_W'((i + NUM_WAYS - 1) % NUM_WAYS);
            end
            head_q <= '0;
            tail_q <= WAY_W'(NUM_WAYS - 1);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            next_q <= next_d;
            prev_q <= prev_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/lru_list_sa.sv
// Set-associative LRU tracker: per-set recency lists plus a registered
// victim (LRU way) query port.
module lru_list_sa
    import lru_pkg::*;
#(
    parameter int NUM_WAYS = 8,
    parameter int NUM_SETS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    lru_list_sa_if.slave bus
);

    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = set_w(NUM_SETS);

    // One extra bit so the limits themselves are representable.
    localparam logic [SET_W:0] SET_LIM = (SET_W + 1)'(NUM_SETS);
    localparam logic [WAY_W:0] WAY_LIM = (WAY_W + 1)'(NUM_WAYS);

    if (NUM_WAYS < 2) begin : g_bad_ways
        $error("lru_list_sa: NUM_WAYS must be >= 2");
    end
    if (NUM_SETS < 1) begin : g_bad_sets
        $error("lru_list_sa: NUM_SETS must be >= 1");
    end

    logic                op_in_range;
    logic                qry_in_range;
    logic [NUM_SETS-1:0] set_en;
    logic [WAY_W-1:0]    set_tail [NUM_SETS];
    logic [WAY_W-1:0]    tail_sel;

    logic             op_err_q, op_err_d;
    logic             vic_valid_q, vic_valid_d;
    logic [WAY_W-1:0] vic_way_q, vic_way_d;

    assign op_in_range  = ({1'b0, bus.op_set} < SET_LIM) && ({1'b0, bus.op_way} < WAY_LIM);
    assign qry_in_range = ({1'b0, bus.qry_set} < SET_LIM);

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        lru_list_set #(
            .NUM_WAYS (NUM_WAYS),
            .WAY_W    (WAY_W)
        ) u_set (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (set_en[s]),
            .op_type (bus.op_type),
            .way     (bus.op_way),
            .tail    (set_tail[s])
        );
    end

    // Decode the op into a one-hot set enable, select the queried tail and
    // form the next values of the output registers.
    always_comb begin
        set_en   = '0;
        tail_sel = '0;
        for (int s = 0; s < NUM_SETS; s++) begin
            if (bus.op_valid && op_in_range && (bus.op_set == SET_W'(s))) begin
                set_en[s] = 1'b1;
            end
            if (bus.qry_set == SET_W'(s)) begin
                tail_sel = set_tail[s];
            end
        end
        op_err_d    = bus.op_valid && !op_in_range;
        vic_valid_d = bus.qry_valid && qry_in_range;
        // Out-of-range or absent query keeps the last reported victim.
        vic_way_d   = vic_valid_d ? tail_sel : vic_way_q;
    end

    // Output registers; the query sees the pre-op tail (no bypass).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_err_q    <= 1'b0;
            vic_valid_q <= 1'b0;
            vic_way_q   <= '0;
        end else begin
            op_err_q    <= op_err_d;
            vic_valid_q <= vic_valid_d;
            vic_way_q   <= vic_way_d;
        end
    end

    assign bus.op_err    = op_err_q;
    assign bus.vic_valid = vic_valid_q;
    assign bus.vic_way   = vic_way_q;

endmodule

// File: tb/tb_lru_list_sa.sv
// Directed and model-checked bench for lru_list_sa (4x4 main instance plus a
// 6-way / 3-set instance for range errors).
module tb_lru_list_sa;
    import lru_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lru_list_sa_if #(.NUM_WAYS(4), .NUM_SETS(4)) bus4 ();
    lru_list_sa_if #(.NUM_WAYS(6), .NUM_SETS(3)) bus6 ();

    lru_list_sa #(.NUM_WAYS(4), .NUM_SETS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    lru_list_sa #(.NUM_WAYS(6), .NUM_SETS(3)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6.slave)
    );

    always #5 clk = ~clk;

    // Reference model: ord[set][pos], position 0 is MRU, position 3 is LRU.
    int ord [4][4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pack(input int a, input int b, input int c, input int d);
        logic [1:0] pa, pb, pc, pd;
        pa = 2'(a); pb = 2'(b); pc = 2'(c); pd = 2'(d);
        return {pa, pb, pc, pd};
    endfunction

    // Walk the DUT list of set s from head along next pointers.
    function automatic logic [7:0] get_order(input int s);
        logic [1:0] h;
        logic [1:0] nx [4];
        h = '0;
        nx = '{default: '0};
        case (s)
            0: begin h = dut.g_set[0].u_set.head_q; nx = dut.g_set[0].u_set.next_q; end
            1: begin h = dut.g_set[1].u_set.head_q; nx = dut.g_set[1].u_set.next_q; end
            2: begin h = dut.g_set[2].u_set.head_q; nx = dut.g_set[2].u_set.next_q; end
            default: begin h = dut.g_set[3].u_set.head_q; nx = dut.g_set[3].u_set.next_q; end
        endcase
        return {h, nx[h], nx[nx[h]], nx[nx[nx[h]]]};
    endfunction

    function automatic logic [7:0] model_order(input int s);
        return pack(ord[s][0], ord[s][1], ord[s][2], ord[s][3]);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 4; i++)
                ord[s][i] = i;
    endtask

    task automatic model_op(input int t, input int s, input int w);
        int pos;
        pos = 0;
        for (int i = 0; i < 4; i++)
            if (ord[s][i] == w) pos = i;
        if (t == 0) begin
            for (int j = pos; j > 0; j--) ord[s][j] = ord[s][j-1];
            ord[s][0] = w;
        end else begin
            for (int j = pos; j < 3; j++) ord[s][j] = ord[s][j+1];
            ord[s][3] = w;
        end
    endtask

    task automatic op4(input lru_op_e t, input int s, input int w);
        bus4.op_valid = 1'b1;
        bus4.op_type  = t;
        bus4.op_set   = 2'(s);
        bus4.op_way   = 2'(w);
        step();
        bus4.op_valid = 1'b0;
    endtask

    task automatic qry4(input int s);
        bus4.qry_valid = 1'b1;
        bus4.qry_set   = 2'(s);
        step();
        bus4.qry_valid = 1'b0;
    endtask

    initial begin
        int exp_vic;
        int t, s, w, qs;
        logic ov, qv;

        clk = 1'b0; rst_n = 1'b0; checks = 0; errors = 0;
        bus4.op_valid = 1'b0; bus4.op_type = LRU_TOUCH; bus4.op_set = '0; bus4.op_way = '0;
        bus4.qry_valid = 1'b0; bus4.qry_set = '0;
        bus6.op_valid = 1'b0; bus6.op_type = LRU_TOUCH; bus6.op_set = '0; bus6.op_way = '0;
        bus6.qry_valid = 1'b0; bus6.qry_set = '0;
        model_reset();

        // Reset state.
        #12;
        check("rst_op_err", 32'(bus4.op_err), 32'd0);
        check("rst_vic_valid", 32'(bus4.vic_valid), 32'd0);
        check("rst_vic_way", 32'(bus4.vic_way), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) check($sformatf("rst_order_s%0d", k), 32'(get_order(k)), 32'h1B);
        qry4(0);
        check("rst_q_valid", 32'(bus4.vic_valid), 32'd1);
        check("rst_q_way", 32'(bus4.vic_way), 32'd3);
        step();
        check("vic_valid_pulse", 32'(bus4.vic_valid), 32'd0);
        check("vic_way_hold", 32'(bus4.vic_way), 32'd3);
        for (int k = 1; k < 4; k++) begin
            qry4(k);
            check($sformatf("rst_q_s%0d", k), 32'(bus4.vic_way), 32'd3);
        end

        // TOUCH tail, then TOUCH head (no change).
        op4(LRU_TOUCH, 0, 3);
        check("touch_tail_order", 32'(get_order(0)), 32'(pack(3, 0, 1, 2)));
        check("touch_no_err", 32'(bus4.op_err), 32'd0);
        qry4(0);
        check("touch_tail_vic", 32'(bus4.vic_way), 32'd2);
        op4(LRU_TOUCH, 0, 3);
        check("touch_head_order", 32'(get_order(0)), 32'(pack(3, 0, 1, 2)));
        qry4(0);
        check("touch_head_vic", 32'(bus4.vic_way), 32'd2);

        // TOUCH middle, DEMOTE middle, set isolation.
        op4(LRU_TOUCH, 0, 1);
        check("touch_mid_order", 32'(get_order(0)), 32'(pack(1, 3, 0, 2)));
        op4(LRU_DEMOTE, 0, 3);
        check("demote_mid_order", 32'(get_order(0)), 32'(pack(1, 0, 2, 3)));
        qry4(0);
        check("demote_mid_vic", 32'(bus4.vic_way), 32'd3);
        qry4(1);
        check("iso_s1_vic", 32'(bus4.vic_way), 32'd3);
        check("iso_s1_order", 32'(get_order(1)), 32'h1B);

        // DEMOTE head, then DEMOTE tail (no change).
        op4(LRU_DEMOTE, 0, 1);
        check("demote_head_order", 32'(get_order(0)), 32'(pack(0, 2, 3, 1)));
        qry4(0);
        check("demote_head_vic", 32'(bus4.vic_way), 32'd1);
        op4(LRU_DEMOTE, 0, 1);
        check("demote_tail_order", 32'(get_order(0)), 32'(pack(0, 2, 3, 1)));

        // Same-cycle query and op: pre-op tail is returned.
        bus4.qry_valid = 1'b1; bus4.qry_set = 2'd0;
        op4(LRU_TOUCH, 0, 1);
        bus4.qry_valid = 1'b0;
        check("same_cyc_vic", 32'(bus4.vic_way), 32'd1);
        qry4(0);
        check("post_op_vic", 32'(bus4.vic_way), 32'd3);

        // Range errors on the 6-way / 3-set instance.
        bus6.op_valid = 1'b1; bus6.op_type = LRU_TOUCH; bus6.op_set = 2'd0; bus6.op_way = 3'd6;
        step();
        bus6.op_valid = 1'b0;
        check("w6_op_err", 32'(bus6.op_err), 32'd1);
        bus6.qry_valid = 1'b1; bus6.qry_set = 2'd0;
        step();
        bus6.qry_valid = 1'b0;
        check("w6_err_pulse", 32'(bus6.op_err), 32'd0);
        check("w6_no_change", 32'(bus6.vic_way), 32'd5);
        check("w6_head", 32'(dut6.g_set[0].u_set.head_q), 32'd0);
        bus6.op_valid = 1'b1; bus6.op_set = 2'd3; bus6.op_way = 3'd5;
        bus6.qry_valid = 1'b1; bus6.qry_set = 2'd3;
        step();
        bus6.op_valid = 1'b0; bus6.qry_valid = 1'b0;
        check("s3_op_err", 32'(bus6.op_err), 32'd1);
        check("s3_qry_invalid", 32'(bus6.vic_valid), 32'd0);
        check("s3_qry_hold", 32'(bus6.vic_way), 32'd5);
        bus6.op_valid = 1'b1; bus6.op_set = 2'd0; bus6.op_way = 3'd5;
        step();
        bus6.op_valid = 1'b0;
        check("w5_no_err", 32'(bus6.op_err), 32'd0);
        bus6.qry_valid = 1'b1; bus6.qry_set = 2'd0;
        step();
        bus6.qry_valid = 1'b0;
        check("w5_vic", 32'(bus6.vic_way), 32'd4);

        // Random ops against the model, with a reset in the middle.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #2;
        model_reset();
        exp_vic = 0;
        rst_n = 1'b1;
        for (int it = 0; it < 10000; it++) begin
            if (it == 5000) begin
                bus4.op_valid = 1'b1; bus4.op_type = LRU_DEMOTE; bus4.op_set = 2'd2; bus4.op_way = 2'd0;
                #2;
                rst_n = 1'b0;
                #1;
                check("mid_rst_order", 32'(get_order(0)), 32'h1B);
                check("mid_rst_vic_valid", 32'(bus4.vic_valid), 32'd0);
                step();
                check("mid_rst_hold", 32'(get_order(2)), 32'h1B);
                bus4.op_valid = 1'b0;
                rst_n = 1'b1;
                model_reset();
                exp_vic = 0;
                qry4(2);
                check("mid_rst_q", 32'(bus4.vic_way), 32'd3);
                exp_vic = 3;
            end
            ov = ($urandom_range(0, 3) != 0);
            qv = ($urandom_range(0, 1) != 0);
            t  = $urandom_range(0, 1);
            s  = $urandom_range(0, 3);
            w  = $urandom_range(0, 3);
            qs = $urandom_range(0, 3);
            bus4.op_valid = ov; bus4.op_type = lru_op_e'(t); bus4.op_set = 2'(s); bus4.op_way = 2'(w);
            bus4.qry_valid = qv; bus4.qry_set = 2'(qs);
            if (qv) exp_vic = ord[qs][3];
            if (ov) model_op(t, s, w);
            step();
            check("rnd_vic_valid", 32'(bus4.vic_valid), 32'(qv));
            check("rnd_vic_way", 32'(bus4.vic_way), 32'(exp_vic));
            check("rnd_op_err", 32'(bus4.op_err), 32'd0);
            for (int k = 0; k < 4; k++) check("rnd_order", 32'(get_order(k)), 32'(model_order(k)));
        end
        bus4.op_valid = 1'b0; bus4.qry_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
